// File: rtl/l2_pkg.sv
// Shared types and default geometry for the L1/L2 block-transfer interface.
package l2_pkg;

  localparam int unsigned L2_XLEN            = 32;
  localparam int unsigned L2_WORDS_PER_BLOCK = 4;

  typedef enum logic {
    L2_READ  = 1'b0,
    L2_WRITE = 1'b1
  } l2_op_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER
  } l2_state_e;

endpackage

// File: rtl/l2_backing_store.sv
// Word-addressed backing array: one combinational read port, one synchronous write port.
module l2_backing_store #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata,
  // Preload hook for block-level benches; tied off when used inside the responder.
  input  logic            preload_we,
  input  logic [AW-1:0]   preload_addr,
  input  logic [XLEN-1:0] preload_wdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (preload_we) begin
      mem[preload_addr] <= preload_wdata;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/l2_responder.sv
// L2-side block responder: captures a request, waits a fixed latency, then streams one
// word per cycle to or from the backing store.
module l2_responder
  import l2_pkg::*;
#(
  parameter int unsigned XLEN            = L2_XLEN,
  parameter int unsigned WORDS_PER_BLOCK = L2_WORDS_PER_BLOCK,
  parameter int unsigned MEM_BLOCKS      = 256,
  parameter int unsigned ACCESS_LATENCY  = 2,
  localparam int unsigned BlkW           = $clog2(MEM_BLOCKS),
  localparam int unsigned IdxW           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            l2_access,
  input  logic            l2_op,
  input  logic [BlkW-1:0] l2_block_address,
  input  logic [XLEN-1:0] l2_wdata,
  output logic            l2_word_valid,
  output logic [IdxW-1:0] l2_word_index,
  output logic [XLEN-1:0] l2_rdata,
  output logic            l2_done,
  output logic            l2_busy
);

  localparam int unsigned LatW = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [LatW-1:0] LatInit = LatW'(ACCESS_LATENCY - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WORDS_PER_BLOCK - 1);

  l2_state_e       state_q, state_d;
  l2_op_e          op_q, op_d;
  logic [BlkW-1:0] blk_q, blk_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic            mem_we;
  logic [XLEN-1:0] mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= L2_READ;
      blk_q <= '0;
      lat_q <= '0;
      idx_q <= '0;
    end else begin
      op_q  <= op_d;
      blk_q <= blk_d;
      lat_q <= lat_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    blk_d   = blk_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (l2_access) begin
          op_d    = l2_op_e'(l2_op);
          blk_d   = l2_block_address;
          lat_d   = LatInit;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!l2_access) begin
          state_d = IDLE;
        end else if (lat_q == '0) begin
          idx_d   = '0;
          state_d = XFER;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      XFER: begin
        idx_d = idx_q + 1'b1;
        if (!l2_access || idx_q == IdxLast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A write beat coincident with reset must not reach the array.
  always_comb begin
    l2_word_valid = 1'b0;
    l2_word_index = '0;
    l2_rdata      = '0;
    l2_done       = 1'b0;
    l2_busy       = (state_q != IDLE);
    mem_we        = 1'b0;
    if (state_q == XFER) begin
      l2_word_valid = 1'b1;
      l2_word_index = idx_q;
      l2_done       = l2_access && (idx_q == IdxLast);
      if (op_q == L2_READ) begin
        l2_rdata = mem_rdata;
      end else begin
        mem_we = !reset;
      end
    end
  end

  l2_backing_store #(
    .XLEN  (XLEN),
    .DEPTH (MEM_BLOCKS * WORDS_PER_BLOCK)
  ) u_store (
    .clk           (clk),
    .we            (mem_we),
    .waddr         ({blk_q, idx_q}),
    .wdata         (l2_wdata),
    .raddr         ({blk_q, idx_q}),
    .rdata         (mem_rdata),
    .preload_we    (1'b0),
    .preload_addr  ('0),
    .preload_wdata ('0)
  );

endmodule

// File: tb/tb_l2_responder.sv
// Randomized directed bench for l2_responder against a cycle-level transfer model.
module tb_l2_responder;
  import l2_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        l2_access;
  logic        l2_op;
  logic [7:0]  l2_block_address;
  logic [31:0] l2_wdata;

  logic        v0, d0, b0, v1, d1, b1;
  logic [1:0]  i0, i1;
  logic [31:0] r0, r1;

  bit          cur;
  logic        s_valid, s_done, s_busy;
  logic [1:0]  s_idx;
  logic [31:0] s_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  assign s_valid = cur ? v1 : v0;
  assign s_done  = cur ? d1 : d0;
  assign s_busy  = cur ? b1 : b0;
  assign s_idx   = cur ? i1 : i0;
  assign s_rdata = cur ? r1 : r0;

  l2_responder #(
    .XLEN(32), .WORDS_PER_BLOCK(4), .MEM_BLOCKS(256), .ACCESS_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .l2_access(l2_access), .l2_op(l2_op),
    .l2_block_address(l2_block_address), .l2_wdata(l2_wdata),
    .l2_word_valid(v0), .l2_word_index(i0), .l2_rdata(r0), .l2_done(d0), .l2_busy(b0)
  );

  l2_responder #(
    .XLEN(32), .WORDS_PER_BLOCK(4), .MEM_BLOCKS(256), .ACCESS_LATENCY(1)
  ) dut1 (
    .clk(clk), .reset(reset), .l2_access(l2_access), .l2_op(l2_op),
    .l2_block_address(l2_block_address), .l2_wdata(l2_wdata),
    .l2_word_valid(v1), .l2_word_index(i1), .l2_rdata(r1), .l2_done(d1), .l2_busy(b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int key(input bit sel, input logic [7:0] blk, input int k);
    return (sel ? 100000 : 0) + int'(blk) * 4 + k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string t);
    chk({t, " idle busy"}, s_busy, 0);
    chk({t, " idle valid"}, s_valid, 0);
    chk({t, " idle done"}, s_done, 0);
    chk({t, " idle index"}, s_idx, 0);
    chk({t, " idle rdata"}, s_rdata, 0);
  endtask

  // One block transfer starting in an IDLE cycle. abort/rst give the beat on which
  // l2_access drops or reset rises (-1 for none); chain keeps l2_access high and
  // switches op/address on the done cycle.
  task automatic xfer(input bit sel, input bit wr, input logic [7:0] blk,
                      input logic [31:0] wd [4], input int abort_beat, input int rst_beat,
                      input bit chain, input bit nwr, input logic [7:0] nblk);
    int    lat;
    bit    exp_done;
    string t;
    lat = sel ? 1 : 2;
    cur = sel;
    t = $sformatf("%s%s b%0d", sel ? "L1 " : "", wr ? "wr" : "rd", blk);
    l2_access = 1'b1;
    l2_op = wr;
    l2_block_address = blk;
    l2_wdata = $urandom;
    @(negedge clk);
    chk({t, " capture busy"}, s_busy, 0);
    chk({t, " capture valid"}, s_valid, 0);
    step();
    for (int c = 0; c < lat; c++) begin
      l2_op = 1'($urandom);
      l2_block_address = 8'($urandom);
      l2_wdata = $urandom;
      @(negedge clk);
      chk($sformatf("%s wait%0d busy", t, c), s_busy, 1);
      chk($sformatf("%s wait%0d valid", t, c), s_valid, 0);
      chk($sformatf("%s wait%0d done", t, c), s_done, 0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      l2_wdata = wd[k];
      l2_op = 1'($urandom);
      l2_block_address = 8'($urandom);
      if (k == abort_beat) l2_access = 1'b0;
      if (k == rst_beat) reset = 1'b1;
      exp_done = (k == 3) && (k != abort_beat);
      @(negedge clk);
      chk($sformatf("%s beat%0d valid", t, k), s_valid, 1);
      chk($sformatf("%s beat%0d index", t, k), s_idx, k);
      chk($sformatf("%s beat%0d done", t, k), s_done, exp_done);
      chk($sformatf("%s beat%0d busy", t, k), s_busy, 1);
      if (!wr && ref_mem.exists(key(sel, blk, k)))
        chk($sformatf("%s beat%0d rdata", t, k), s_rdata, ref_mem[key(sel, blk, k)]);
      if (wr && k != rst_beat) ref_mem[key(sel, blk, k)] = wd[k];
      if (k == 3 && chain) begin
        l2_op = nwr;
        l2_block_address = nblk;
      end
      step();
      if (k == abort_beat || k == rst_beat) begin
        reset = 1'b0;
        l2_access = 1'b0;
        @(negedge clk);
        chk_idle({t, " after cut"});
        step();
        return;
      end
    end
    if (!chain) begin
      l2_access = 1'b0;
      @(negedge clk);
      chk_idle({t, " after done"});
      step();
    end
  endtask

  initial begin
    logic [31:0] wd [4];
    bit          wr, nwr;
    logic [7:0]  blk, nblk;
    int          ab, rb;
    bit          chain;

    reset = 1'b1;
    l2_access = 1'b0;
    l2_op = 1'b0;
    l2_block_address = '0;
    l2_wdata = '0;
    cur = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    cur = 1'b1;
    #0;
    chk_idle("reset L1");
    step();

    // Known contents for blocks 0..15.
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 4; k++) wd[k] = $urandom;
      xfer(0, 1, 8'(b), wd, -1, -1, 0, 0, 0);
    end

    wd = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    xfer(0, 1, 8'd5, wd, -1, -1, 0, 0, 0);
    xfer(0, 0, 8'd5, wd, -1, -1, 0, 0, 0);

    wd = '{32'd11, 32'd22, 32'd33, 32'd44};
    xfer(0, 1, 8'd9, wd, -1, -1, 0, 0, 0);
    xfer(0, 0, 8'd9, wd, -1, -1, 0, 0, 0);
    xfer(0, 0, 8'd8, wd, -1, -1, 0, 0, 0);
    xfer(0, 0, 8'd10, wd, -1, -1, 0, 0, 0);

    // Flush then load, switching on the done cycle.
    for (int k = 0; k < 4; k++) wd[k] = $urandom;
    xfer(0, 1, 8'd3, wd, -1, -1, 1, 0, 8'd7);
    xfer(0, 0, 8'd7, wd, -1, -1, 0, 0, 0);
    xfer(0, 0, 8'd3, wd, -1, -1, 0, 0, 0);

    // Abort on the 2nd write beat, then reset on read beat 1.
    for (int k = 0; k < 4; k++) wd[k] = $urandom;
    xfer(0, 1, 8'd2, wd, 1, -1, 0, 0, 0);
    xfer(0, 0, 8'd2, wd, -1, -1, 0, 0, 0);
    xfer(0, 0, 8'd5, wd, -1, 1, 0, 0, 0);
    xfer(0, 0, 8'd5, wd, -1, -1, 0, 0, 0);

    nwr = 1'($urandom);
    nblk = 8'($urandom_range(0, 15));
    for (int n = 0; n < 30; n++) begin
      wr = nwr;
      blk = nblk;
      nwr = 1'($urandom);
      nblk = 8'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) wd[k] = $urandom;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1;
      rb = (ab < 0 && $urandom_range(0, 6) == 0) ? int'($urandom_range(0, 3)) : -1;
      chain = (ab < 0 && rb < 0) ? 1'($urandom) : 1'b0;
      xfer(0, wr, blk, wd, ab, rb, chain, nwr, nblk);
    end

    // Latency-1 instance at the top block address.
    l2_access = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    wd = '{32'h0000_0B00, 32'h0000_0B01, 32'h0000_0B02, 32'h0000_0B03};
    xfer(1, 1, 8'd0, wd, -1, -1, 0, 0, 0);
    wd = '{32'hFFFF_0000, 32'hFFFF_0001, 32'hFFFF_0002, 32'hFFFF_0003};
    xfer(1, 1, 8'd255, wd, -1, -1, 0, 0, 0);
    xfer(1, 0, 8'd255, wd, -1, -1, 1, 0, 8'd0);
    xfer(1, 0, 8'd0, wd, -1, -1, 1, 0, 8'd255);
    xfer(1, 0, 8'd255, wd, -1, -1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
